rsa_modexp: RTL
===============

RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand, modulus and result width in bits (matches the 2x32-bit key width produced by the key generator).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have port msg, input, WIDTH bits: base (plaintext or ciphertext), captured on accepted start.
REQ-006 SHALL have port exp, input, WIDTH bits: exponent (e or d), captured on accepted start.
REQ-007 SHALL have port n, input, WIDTH bits: modulus p*q, captured on accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse while in DONE.
REQ-010 SHALL have port err, output, 1 bit: operand error flag, valid with done and held until the next accepted start.
REQ-011 SHALL have port result, output, WIDTH bits: msg^exp mod n, held from done until the next accepted start.

Function
REQ-012 SHALL implement a state machine with states IDLE, CHECK, MUL, SQR and DONE.
REQ-013 SHALL, in IDLE with start=1, capture msg, exp and n into internal registers, clear err, and enter CHECK.
REQ-014 SHALL ignore start in every state other than IDLE, with no effect on the operation in progress.
REQ-015 SHALL, in CHECK, go to DONE with err=1 and result=0 when n==0 or msg>=n.
REQ-016 SHALL, in CHECK with valid operands, set acc = (n==1) ? 0 : 1, base = msg and bit index = 0, then enter MUL.
REQ-017 SHALL compute the modular product bit-serially, MSB first, one operand bit per cycle, over exactly WIDTH cycles.
REQ-018 SHALL perform each modular-product step as: R = 2R, subtract n if R >= n; if the multiplier bit is 1, R = R + multiplicand, subtract n if R >= n.
REQ-019 SHALL compute all intermediate sums at WIDTH+1 bits so that no carry is lost.
REQ-020 SHALL, in MUL, always compute acc*base mod n, and SHALL commit the product to acc only when exp[index]=1 (constant time).
REQ-021 SHALL, in SQR, compute base*base mod n, commit it to base, then increment the index.
REQ-022 SHALL go from SQR to MUL while index < WIDTH, and otherwise to DONE.
REQ-023 SHALL, in DONE, drive done=1 and result=acc for one cycle, then return to IDLE.
REQ-024 SHALL, for valid operands, assert done 2*WIDTH*WIDTH+2 rising edges after the edge that samples start.
REQ-025 SHALL, for the error path, assert done 2 edges after the edge that samples start.
REQ-026 SHALL return result = (n==1) ? 0 : 1 when exp==0.

Reset
REQ-027 SHALL, while reset=0, immediately force state=IDLE, busy=0, done=0, err=0, result=0 and all internal registers to 0, regardless of clk.
REQ-028 SHALL abort any in-progress operation on reset with no done pulse, and SHALL accept a new start on the first edge after reset is released.

Configuration
REQ-029 SHALL support the macro RSA_MODEXP_EARLY_EXIT_EN.
REQ-030 SHALL, with RSA_MODEXP_EARLY_EXIT_EN defined, go from SQR to DONE as soon as every remaining exp bit above the current index is 0; latency is then 2*WIDTH*k+2, where k = max(1, index of the highest set bit of exp + 1).
REQ-031 SHALL, without RSA_MODEXP_EARLY_EXIT_EN, keep the fixed latency of REQ-024 independent of exp.

Verification (all with WIDTH=16)
REQ-032 SHALL cover: msg=4, exp=3, n=33 -> result=31, err=0, done exactly 514 edges after start.
REQ-033 SHALL cover: msg=31, exp=7, n=33 -> result=4, confirming the round trip with REQ-032.
REQ-034 SHALL cover: msg=7, exp=0, n=33 -> result=1; msg=0, exp=5, n=1 -> result=0.
REQ-035 SHALL cover: msg=40, n=33 -> err=1, result=0, done 2 edges after start; separately n=0 -> err=1.
REQ-036 SHALL cover: start pulses during busy -> ignored, first result unchanged; reset=0 at cycle 100 -> busy=0 at once, no done, next start (msg=4, exp=3, n=33) -> result=31.
REQ-037 SHALL cover: with RSA_MODEXP_EARLY_EXIT_EN defined, msg=4, exp=3, n=33 -> result=31 with done 66 edges after start; without the macro -> done at 514.

Source files
------------

// File: rtl/rsa_modexp.sv
// ============================================================================
// Module   : rsa_modexp
// Brief    : Constant-time modular exponentiation result = msg^exp mod n.
//            Uses LSB-first square-and-multiply with bit-serial MSB-first
//            modular products. Optional macro: RSA_MODEXP_EARLY_EXIT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rsa_modexp #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] c_last = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_SQR   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_mplier;
  logic [IW-1:0]    r_bit;
  logic [IW-1:0]    r_idx;

  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sum_red;
  logic [WIDTH:0]   w_n_ext;
  logic [WIDTH-1:0] w_step;
  logic             w_finish;
  logic             w_unused_ok;

  // One product step: R = 2R mod n, then R = R + base mod n when the
  // multiplier bit is set. Everything is WIDTH+1 bits so carries survive.
  always_comb begin
    w_n_ext   = {1'b0, r_n};
    w_dbl     = {r_prod, 1'b0};
    w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_sum     = w_dbl_red + {1'b0, r_base};
    w_sum_red = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    w_step    = r_mplier[WIDTH-1] ? w_sum_red[WIDTH-1:0] : w_dbl_red[WIDTH-1:0];
  end

  // Reduced values are always below n, so their top bit is structurally zero.
  assign w_unused_ok = &{1'b0, w_sum_red[WIDTH]};

`ifdef RSA_MODEXP_EARLY_EXIT_EN
  assign w_finish = (r_idx == c_last) || (r_exp[WIDTH-1:1] == '0);
`else
  assign w_finish = (r_idx == c_last);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_acc    <= '0;
      r_exp    <= '0;
      r_n      <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_bit    <= '0;
      r_idx    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= msg;
            r_exp   <= exp;
            r_n     <= n;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if ((r_n == '0) || (r_base >= r_n)) begin
            err     <= 1'b1;
            r_acc   <= '0;
            r_state <= S_DONE;
          end else begin
            r_acc    <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_mplier <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_prod   <= '0;
            r_bit    <= '0;
            r_idx    <= '0;
            r_state  <= S_MUL;
          end
        end

        // acc * base is always computed; the commit is gated by the exp bit
        S_MUL: begin
          r_prod   <= w_step;
          r_mplier <= {r_mplier[WIDTH-2:0], 1'b0};
          r_bit    <= r_bit + IW'(1);
          if (r_bit == c_last) begin
            if (r_exp[0]) begin
              r_acc <= w_step;
            end
            r_prod   <= '0;
            r_mplier <= r_base;
            r_bit    <= '0;
            r_state  <= S_SQR;
          end
        end

        S_SQR: begin
          r_prod   <= w_step;
          r_mplier <= {r_mplier[WIDTH-2:0], 1'b0};
          r_bit    <= r_bit + IW'(1);
          if (r_bit == c_last) begin
            r_base   <= w_step;
            r_exp    <= {1'b0, r_exp[WIDTH-1:1]};
            r_idx    <= r_idx + IW'(1);
            r_prod   <= '0;
            r_mplier <= r_acc;
            r_bit    <= '0;
            r_state  <= w_finish ? S_DONE : S_MUL;
          end
        end

        S_DONE: begin
          done    <= 1'b1;
          result  <= r_acc;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
